// File: rtl/mips_pkg.sv
// Shared MIPS types: opcode/ALU encodings plus the fetch-stage state enum
// and jump-target helper used by the instruction fetch unit.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } t_opcode;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } t_alu_op;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_HOLD
  } t_fetch_state;

  // All-zero word is sll $0,$0,0, i.e. a NOP, so a cleared register is harmless.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] instr_index);
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// Handshake: req and addr are held stable from the first request cycle until
// the master samples ack high on a rising edge; rdata is valid only in that cycle.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: jump beats taken branch beats sequential.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        Jump,
  input  logic        BeqValid,
  input  logic [31:0] branch_offset,
  input  logic [25:0] instr_index,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_target(pc_plus4, instr_index);
    end else if (BeqValid) begin
      // Wraps modulo 2^32; a negative offset simply walks backwards.
      next_pc = pc_plus4 + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, holds the fetched word for
// decode until it is consumed, then steps the PC (sequential, jump or branch).
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                Jump,
  input  logic                BeqValid,
  input  logic [31:0]         branch_offset,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output t_fetch_state        state
);

  t_fetch_state state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         load_instr;
  logic         advance_pc;
  logic [31:0]  next_pc;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign state       = state_q;
  assign imem.addr   = pc_q;

  pc_next u_pc_next (
    .pc_plus4      (pc_plus4),
    .Jump          (Jump),
    .BeqValid      (BeqValid),
    .branch_offset (branch_offset),
    .instr_index   (instr_q[25:0]),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_instr) begin
        instr_q <= imem.rdata;
        valid_q <= 1'b1;
      end
      if (advance_pc) begin
        pc_q    <= next_pc;
        valid_q <= 1'b0;
      end
    end
  end

  // ack outside FETCH_REQ never loads: only the REQ arm looks at it.
  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    advance_pc = 1'b0;
    imem.req   = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          load_instr = 1'b1;
          state_d    = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (!stall) begin
          advance_pc = 1'b1;
          state_d    = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch/jump/branch/stall/reset sequences,
// memory responder with scoreboard of expected fetch addresses.
module tb_instr_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        Jump;
  logic        BeqValid;
  logic [31:0] branch_offset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  t_fetch_state state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit stray_ack = 1'b0;

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus.master),
    .stall         (stall),
    .Jump          (Jump),
    .BeqValid      (BeqValid),
    .branch_offset (branch_offset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .state         (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_000C || addr == 32'h0000_0040) return 32'h0800_0010;
    return 32'h2000_0000 | {16'h0000, addr[15:0]};
  endfunction

  assign imem_bus.rdata = mem_word(imem_bus.addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder + scoreboard monitor
  always @(negedge clk) begin
    if (imem_bus.req) begin
      if (wait_cnt >= ack_delay) begin
        imem_bus.ack = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_bus.ack = 1'b0;
        wait_cnt++;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL fetch_unexpected: got addr %h expected no request", imem_bus.addr);
      end else if (imem_bus.ack) begin
        check("fetch_addr", imem_bus.addr, exp_q.pop_front());
      end else begin
        check("req_addr_stable", imem_bus.addr, exp_q[0]);
      end
    end else begin
      imem_bus.ack = stray_ack;
      wait_cnt = 0;
    end
  end

  // driver: wait for a held instruction, optionally stall, then consume it
  task automatic consume(input logic j, input logic b, input logic [31:0] off,
                         input logic [31:0] exp_next, input int stall_cycles,
                         input int exp_wait, input int next_delay);
    int n = 0;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL valid_timeout: got no instr_valid after %0d cycles expected one", n);
      return;
    end
    if (exp_wait > 0) check("valid_spacing", n, exp_wait);
    check("held_instr", instr, mem_word(pc));
    held_pc    = pc;
    held_instr = instr;
    for (int i = 0; i < stall_cycles; i++) begin
      stall     = 1'b1;
      stray_ack = 1'b1;
      Jump      = (i % 2 == 0);
      @(negedge clk);
      check("stall_pc", pc, held_pc);
      check("stall_instr", instr, held_instr);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_no_req", {31'b0, imem_bus.req}, 32'd0);
    end
    stray_ack     = 1'b0;
    Jump          = j;
    BeqValid      = b;
    branch_offset = off;
    stall         = 1'b0;
    ack_delay     = next_delay;
    exp_q.push_back(exp_next);
    @(negedge clk);
    check("next_pc", pc, exp_next);
    check("valid_cleared", {31'b0, instr_valid}, 32'd0);
    check("state_req", 32'(state), 32'(FETCH_REQ));
    Jump     = 1'b0;
    BeqValid = 1'b0;
    stall    = 1'b1;
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    stall         = 1'b1;
    Jump          = 1'b0;
    BeqValid      = 1'b0;
    branch_offset = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_bus.req}, 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_pc_plus4", pc_plus4, 32'h0000_0004);
    check("rst_addr", imem_bus.addr, 32'h0000_0000);
    check("rst_instr", instr, 32'h0000_0000);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_state", 32'(state), 32'(FETCH_IDLE));
    exp_q.push_back(32'h0000_0000);
    rst_n = 1'b1;

    // sequential fetch 0,4,8,12 then J from 12 and J at 0x40 back to 0x40
    consume(1'b0, 1'b0, 32'h0, 32'h0000_0004, 0, 0, 0);
    consume(1'b0, 1'b0, 32'h0, 32'h0000_0008, 0, 1, 0);
    consume(1'b0, 1'b0, 32'h0, 32'h0000_000C, 0, 1, 0);
    consume(1'b1, 1'b0, 32'h0, 32'h0000_0040, 0, 1, 0);
    consume(1'b1, 1'b0, 32'h0, 32'h0000_0040, 0, 1, 0);
    // Jump and BeqValid together: jump wins
    consume(1'b1, 1'b1, 32'h0000_002F, 32'h0000_0040, 0, 1, 0);
    consume(1'b0, 1'b1, 32'h0000_002F, 32'h0000_0100, 0, 1, 0);
    // backward branch 0x104 + (-2 << 2) = 0xFC
    consume(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_00FC, 0, 1, 0);
    // stall 5 cycles with Jump pulsing and stray acks, then sequential with slow memory
    consume(1'b0, 1'b0, 32'h0, 32'h0000_0100, 5, 1, 3);
    consume(1'b0, 1'b0, 32'h0, 32'h0000_0104, 0, 4, 0);
    consume(1'b0, 1'b1, 32'hFFFF_FFC6, 32'h0000_0020, 0, 1, 5);

    // reset while requesting 0x20
    check("pre_rst_req", {31'b0, imem_bus.req}, 32'd1);
    check("pre_rst_addr", imem_bus.addr, 32'h0000_0020);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreq_rst_req", {31'b0, imem_bus.req}, 32'd0);
    check("midreq_rst_pc", pc, 32'h0000_0000);
    check("midreq_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("midreq_rst_state", 32'(state), 32'(FETCH_IDLE));
    check("midreq_rst_pc_plus4", pc_plus4, 32'h0000_0004);
    stray_ack = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("late_ack_instr", instr, 32'h0000_0000);
    check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    stray_ack = 1'b0;
    ack_delay = 0;
    exp_q.push_back(32'h0000_0000);
    rst_n = 1'b1;

    // restart, branch to top of address space, wrap to 0
    consume(1'b0, 1'b0, 32'h0, 32'h0000_0004, 0, 0, 0);
    consume(1'b0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 0, 1, 0);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    consume(1'b0, 1'b0, 32'h0, 32'h0000_0000, 0, 1, 0);

    n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("final_valid", {31'b0, instr_valid}, 32'd1);
    check("final_instr", instr, 32'h2000_0000);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
